// File: rtl/cw_pkg.sv
// rtl/cw_pkg.sv - shared state encoding and CW header-word layout for cw_arbiter
package cw_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_HI = 3'd1,
    ADDR_LO = 3'd2,
    TURN    = 3'd3,
    DATA    = 3'd4,
    DONE    = 3'd5
  } cw_state_e;

  // Low three bits of every ADDR_HI word; lets the far end find frame starts.
  localparam logic [2:0] FRAME_MARK = 3'b111;

  // ADDR_HI word layout: {adr[23:16], 1'b0, len[2:0], we, FRAME_MARK}
  localparam int HI_MARK_LSB = 0;
  localparam int HI_WE_BIT   = 3;
  localparam int HI_LEN_LSB  = 4;
  localparam int HI_ADR_LSB  = 8;

  function automatic logic [15:0] addr_hi_word(input logic [7:0] adr_hi,
                                               input logic [2:0] len,
                                               input logic       we);
    logic [15:0] w;
    w = '0;
    w[HI_ADR_LSB +: 8]  = adr_hi;
    w[HI_LEN_LSB +: 3]  = len;
    w[HI_WE_BIT]        = we;
    w[HI_MARK_LSB +: 3] = FRAME_MARK;
    return w;
  endfunction

endpackage

// File: rtl/cw_rr_arb2.sv
// rtl/cw_rr_arb2.sv - two-way round-robin selector with a one-bit priority pointer
module cw_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // prio_q names the port that wins a tie (0 after reset).
  logic prio_q;
  logic prio_d;

  // One-hot grant; on a tie the pointer decides.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
  end

  // After a taken grant, the other port gets the tie-break.
  always_comb begin
    prio_d = prio_q;
    if (advance && (grant != 2'b00)) begin
      prio_d = grant[0];
    end
  end

  // Pointer register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/cw_arbiter.sv
// rtl/cw_arbiter.sv - two-port CW bus arbiter/master; optional timeout under CW_ARB_TIMEOUT_EN
module cw_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        p0_cyc,
  input  logic        p0_we,
  input  logic [23:0] p0_adr,
  input  logic [2:0]  p0_len,
  input  logic [15:0] p0_wdata,
  output logic [15:0] p0_rdata,
  output logic        p0_ack,
  output logic        p0_err,

  input  logic        p1_cyc,
  input  logic        p1_we,
  input  logic [23:0] p1_adr,
  input  logic [2:0]  p1_len,
  input  logic [15:0] p1_wdata,
  output logic [15:0] p1_rdata,
  output logic        p1_ack,
  output logic        p1_err,

  output logic        cw_req,
  output logic        cw_dir,
  output logic [15:0] cw_io_o,
  output logic        cw_io_oe,
  input  logic [15:0] cw_io_i,
  input  logic        cw_ack,
  input  logic        cw_err
);

  import cw_pkg::*;

  cw_state_e   state_q, state_d;
  logic        ack_prev_q;
  logic [2:0]  beat_cnt_q, beat_cnt_d;
  logic        port_q;
  logic        we_q;
  logic [23:0] adr_q;
  logic [2:0]  len_q;
  logic        drop_q;
  logic [1:0]  ack_q, ack_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] rdata0_q, rdata1_q;
  logic        rd_cap;

  logic [1:0]  grant;
  logic        rr_adv;
  logic        beat;
  logic        gnt_cyc;
  logic        live;
  logic        timeout;
  logic        abort;

  assign rr_adv  = (state_q == IDLE);
  assign beat    = cw_ack & ~ack_prev_q;
  assign gnt_cyc = port_q ? p1_cyc : p0_cyc;
  // Responses go only to a requester that has held cyc for the whole transaction.
  assign live    = gnt_cyc & ~drop_q;
  assign abort   = (state_q != IDLE) && (cw_err || timeout);

  cw_rr_arb2 u_rr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req     ({p1_cyc, p0_cyc}),
    .advance (rr_adv),
    .grant   (grant)
  );

`ifdef CW_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q;

  // Cycles since the last beat while a transaction is open.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state_q == IDLE) || beat) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end

  assign timeout = (state_q != IDLE) && !beat && (to_cnt_q == TO_LAST);
`else
  // TIMEOUT_CYCLES has no effect in this build; a missing ack stalls forever.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;
`endif

  // Next state, beat counting and response pulses; error/timeout overrides all.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    ack_d      = 2'b00;
    err_d      = 2'b00;
    rd_cap     = 1'b0;
    case (state_q)
      IDLE: begin
        beat_cnt_d = 3'd0;
        if (grant != 2'b00) state_d = ADDR_HI;
      end
      ADDR_HI: begin
        if (beat) state_d = ADDR_LO;
      end
      ADDR_LO: begin
        if (beat) state_d = we_q ? DATA : TURN;
      end
      TURN: begin
        state_d = DATA;
      end
      DATA: begin
        if (beat) begin
          rd_cap        = ~we_q;
          ack_d[port_q] = live;
          if (beat_cnt_q == len_q) begin
            state_d    = DONE;
            beat_cnt_d = 3'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort) begin
      state_d       = IDLE;
      beat_cnt_d    = 3'd0;
      ack_d         = 2'b00;
      rd_cap        = 1'b0;
      err_d[port_q] = live;
    end
  end

  // Bus-side outputs decode straight from the state register.
  always_comb begin
    cw_req  = (state_q == ADDR_HI) || (state_q == ADDR_LO) ||
              (state_q == TURN)    || (state_q == DATA);
    cw_dir  = ~we_q && ((state_q == TURN) || (state_q == DATA));
    cw_io_o = 16'h0000;
    case (state_q)
      ADDR_HI: cw_io_o = addr_hi_word(adr_q[23:16], len_q, we_q);
      ADDR_LO: cw_io_o = adr_q[15:0];
      DATA:    cw_io_o = we_q ? (port_q ? p1_wdata : p0_wdata) : 16'h0000;
      default: cw_io_o = 16'h0000;
    endcase
  end

  assign cw_io_oe = ~cw_dir;

  // Core state, edge history and response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ack_prev_q <= 1'b0;
      beat_cnt_q <= 3'd0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata0_q   <= 16'h0000;
      rdata1_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      ack_prev_q <= cw_ack;
      beat_cnt_q <= beat_cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      if (rd_cap && !port_q) rdata0_q <= cw_io_i;
      if (rd_cap &&  port_q) rdata1_q <= cw_io_i;
    end
  end

  // Request attributes are frozen at grant so the requester may change them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      port_q <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= 24'h0;
      len_q  <= 3'd0;
      drop_q <= 1'b0;
    end else if ((state_q == IDLE) && (grant != 2'b00)) begin
      port_q <= grant[1];
      we_q   <= grant[1] ? p1_we  : p0_we;
      adr_q  <= grant[1] ? p1_adr : p0_adr;
      len_q  <= grant[1] ? p1_len : p0_len;
      drop_q <= 1'b0;
    end else if ((state_q != IDLE) && !gnt_cyc) begin
      drop_q <= 1'b1;
    end
  end

  assign p0_ack   = ack_q[0];
  assign p1_ack   = ack_q[1];
  assign p0_err   = err_q[0];
  assign p1_err   = err_q[1];
  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_cw_arbiter.sv
// tb/tb_cw_arbiter.sv - directed vector bench for cw_arbiter
module tb_cw_arbiter;
  import cw_pkg::*;

  logic        i_clk, i_rst;
  logic        p0_cyc, p0_we, p1_cyc, p1_we;
  logic [23:0] p0_adr, p1_adr;
  logic [2:0]  p0_len, p1_len;
  logic [15:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic        cw_req, cw_dir, cw_io_oe, cw_ack, cw_err;
  logic [15:0] cw_io_o, cw_io_i;

  int n_vec = 0;
  int n_bad = 0;
  int n_ack0 = 0, n_ack1 = 0, n_err0 = 0, n_err1 = 0;

  cw_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .p0_cyc(p0_cyc), .p0_we(p0_we), .p0_adr(p0_adr), .p0_len(p0_len),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_cyc(p1_cyc), .p1_we(p1_we), .p1_adr(p1_adr), .p1_len(p1_len),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .cw_req(cw_req), .cw_dir(cw_dir), .cw_io_o(cw_io_o), .cw_io_oe(cw_io_oe),
    .cw_io_i(cw_io_i), .cw_ack(cw_ack), .cw_err(cw_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge i_clk) begin
    if (p0_ack) n_ack0 <= n_ack0 + 1;
    if (p1_ack) n_ack1 <= n_ack1 + 1;
    if (p0_err) n_err0 <= n_err0 + 1;
    if (p1_err) n_err1 <= n_err1 + 1;
  end

  typedef struct {
    logic        c0, c1, ack;
    logic [15:0] io_i;
    logic        req, dir;
    logic [15:0] eio;
    logic [1:0]  pk;
    logic [15:0] rd0;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic c0, input logic c1, input logic ack,
                              input logic [15:0] io_i, input logic req,
                              input logic dir, input logic [15:0] eio,
                              input logic [1:0] pk, input logic [15:0] rd0);
    vec_t v;
    v.c0 = c0; v.c1 = c1; v.ack = ack; v.io_i = io_i;
    v.req = req; v.dir = dir; v.eio = eio; v.pk = pk; v.rd0 = rd0;
    return v;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave side: n data beats plus the two address beats, each a 1-then-0 ack.
  task automatic serve(input int n_data);
    for (int k = 0; k < n_data + 2; k++) begin
      cw_ack = 1'b1; tick();
      cw_ack = 1'b0; tick();
    end
  endtask

  task automatic pulse(input logic [15:0] d);
    cw_io_i = d;
    cw_ack = 1'b1; tick();
    cw_ack = 1'b0; tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1, e0, e1;
    logic [54:0] act_v, exp_v;

    // p0 read FFE000 len3, then p1 write 100080 len0
    tbl[0]  = mk(1,0,0,16'h0000, 0,0,16'h0000,2'b00,16'h0000);
    tbl[1]  = mk(1,0,1,16'h0000, 1,0,16'hFF37,2'b00,16'h0000);
    tbl[2]  = mk(1,0,0,16'h0000, 1,0,16'hE000,2'b00,16'h0000);
    tbl[3]  = mk(1,0,1,16'h0000, 1,0,16'hE000,2'b00,16'h0000);
    tbl[4]  = mk(1,0,0,16'h0000, 1,1,16'h0000,2'b00,16'h0000);
    tbl[5]  = mk(1,0,1,16'h000E, 1,1,16'h0000,2'b00,16'h0000);
    tbl[6]  = mk(1,0,0,16'h0000, 1,1,16'h0000,2'b01,16'h000E);
    tbl[7]  = mk(1,0,1,16'h0100, 1,1,16'h0000,2'b00,16'h000E);
    tbl[8]  = mk(1,0,0,16'h0000, 1,1,16'h0000,2'b01,16'h0100);
    tbl[9]  = mk(1,0,1,16'h0000, 1,1,16'h0000,2'b00,16'h0100);
    tbl[10] = mk(1,0,0,16'h0000, 1,1,16'h0000,2'b01,16'h0000);
    tbl[11] = mk(1,0,1,16'h0000, 1,1,16'h0000,2'b00,16'h0000);
    tbl[12] = mk(0,0,0,16'h0000, 0,0,16'h0000,2'b01,16'h0000);
    tbl[13] = mk(0,0,0,16'h0000, 0,0,16'h0000,2'b00,16'h0000);
    tbl[14] = mk(0,1,0,16'h0000, 0,0,16'h0000,2'b00,16'h0000);
    tbl[15] = mk(0,1,1,16'h0000, 1,0,16'h100F,2'b00,16'h0000);
    tbl[16] = mk(0,1,0,16'h0000, 1,0,16'h0080,2'b00,16'h0000);
    tbl[17] = mk(0,1,1,16'h0000, 1,0,16'h0080,2'b00,16'h0000);
    tbl[18] = mk(0,1,0,16'h0000, 1,0,16'hA0A0,2'b00,16'h0000);
    tbl[19] = mk(0,1,1,16'h0000, 1,0,16'hA0A0,2'b00,16'h0000);
    tbl[20] = mk(0,0,0,16'h0000, 0,0,16'h0000,2'b10,16'h0000);
    tbl[21] = mk(0,0,0,16'h0000, 0,0,16'h0000,2'b00,16'h0000);

    i_rst = 1'b1;
    p0_cyc = 0; p0_we = 0; p0_adr = 24'hFFE000; p0_len = 3'd3; p0_wdata = 16'h5555;
    p1_cyc = 0; p1_we = 1; p1_adr = 24'h100080; p1_len = 3'd0; p1_wdata = 16'hA0A0;
    cw_ack = 0; cw_err = 0; cw_io_i = 16'h0000;
    tick(); tick();
    chk("reset_state",
        {cw_req, cw_dir, cw_io_oe, cw_io_o, p1_ack, p0_ack, p1_err, p0_err, p0_rdata, p1_rdata},
        {1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000, 16'h0000, 16'h0000});
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 22; i++) begin
      p0_cyc = tbl[i].c0; p1_cyc = tbl[i].c1;
      cw_ack = tbl[i].ack; cw_io_i = tbl[i].io_i;
      #1;
      act_v = {cw_req, cw_dir, cw_io_oe, cw_io_o, p1_ack, p0_ack, p1_err, p0_err, p0_rdata, p1_rdata};
      exp_v = {tbl[i].req, tbl[i].dir, ~tbl[i].dir, tbl[i].eio, tbl[i].pk, 2'b00, tbl[i].rd0, 16'h0000};
      if (act_v !== exp_v) $display("FAIL at table row %0d", i);
      chk("table_row", {9'd0, act_v}, {9'd0, exp_v});
      tick();
    end

    // Round-robin: after reset p0 wins; after a lone p0 the tie goes to p1.
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    p0_adr = 24'h123456; p0_len = 3'd0;
    b0 = n_ack0; b1 = n_ack1;
    p0_cyc = 1; p1_cyc = 1; tick();
    chk("arb1_first_hdr", cw_io_o, 16'h1207);
    serve(1);
    chk("arb1_p0_acks", n_ack0, b0 + 1);
    chk("arb1_p1_idle", n_ack1, b1);
    p0_cyc = 0; tick();
    chk("arb1_second_hdr", cw_io_o, 16'h100F);
    serve(1); p1_cyc = 0;
    chk("arb1_p1_acks", n_ack1, b1 + 1);
    p0_cyc = 1; tick(); serve(1); p0_cyc = 0;
    p0_cyc = 1; p1_cyc = 1; tick();
    chk("arb2_first_hdr", cw_io_o, 16'h100F);
    serve(1); p1_cyc = 0; tick();
    chk("arb2_second_hdr", cw_io_o, 16'h1207);
    serve(1); p0_cyc = 0;
    chk("arb2_p0_acks", n_ack0, b0 + 3);
    chk("arb2_p1_acks", n_ack1, b1 + 2);

    // cw_err on the second read beat.
    p0_adr = 24'hFFE000; p0_len = 3'd3;
    b0 = n_ack0; e0 = n_err0; e1 = n_err1;
    p0_cyc = 1; tick();
    pulse(16'h0000); pulse(16'h0000); pulse(16'h1111);
    cw_io_i = 16'h2222; cw_ack = 1; cw_err = 1; tick();
    chk("err_pulse", {p0_err, p0_ack, cw_req}, 3'b100);
    chk("err_state_idle", dut.state_q, IDLE);
    cw_ack = 0; cw_err = 0; p0_cyc = 0; tick();
    chk("err_one_cycle", p0_err, 1'b0);
    for (int k = 0; k < 3; k++) pulse(16'h3333);
    chk("err_acks", n_ack0, b0 + 1);
    chk("err_count", n_err0, e0 + 1);
    chk("err_p1_quiet", n_err1, e1);
    chk("err_rdata", p0_rdata, 16'h1111);

    // Held ack counts once: p1 write, two data beats, first held 5 cycles.
    p1_len = 3'd1; p1_wdata = 16'h5A5A;
    b1 = n_ack1;
    p1_cyc = 1; tick();
    pulse(16'h0000); pulse(16'h0000);
    cw_ack = 1;
    repeat (5) tick();
    chk("held_one_beat", n_ack1, b1 + 1);
    chk("held_still_data", {cw_req, cw_io_o}, {1'b1, 16'h5A5A});
    cw_ack = 0; tick();
    pulse(16'h0000);
    chk("held_done", cw_req, 1'b0);
    tick(); p1_cyc = 0;
    chk("held_total", n_ack1, b1 + 2);

    // Missing ack: timeout abort, or indefinite stall without it.
    e0 = n_err0;
    p0_cyc = 1; tick();
    repeat (15) tick();
    chk("stall_before", {cw_req, p0_err}, 2'b10);
`ifdef CW_ARB_TIMEOUT_EN
    tick();
    chk("timeout_fire", {cw_req, p0_err}, 2'b01);
    p0_cyc = 0; tick();
    chk("timeout_count", n_err0, e0 + 1);
`else
    repeat (25) tick();
    chk("stall_hold", {cw_req, p0_err}, 2'b10);
    chk("stall_no_err", n_err0, e0);
    i_rst = 1; p0_cyc = 0; tick(); i_rst = 0; tick();
`endif

    // Reset in the middle of a read DATA phase, on a beat.
    b0 = n_ack0;
    p0_cyc = 1; tick();
    pulse(16'h0000); pulse(16'h0000); pulse(16'hBEEF);
    chk("mid_rdata", p0_rdata, 16'hBEEF);
    cw_ack = 1; i_rst = 1; tick();
    chk("mid_reset_outs",
        {cw_req, cw_dir, cw_io_oe, cw_io_o, p0_ack, p0_err, p0_rdata},
        {1'b0, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h0000});
    i_rst = 0; cw_ack = 0; p0_cyc = 0; tick();
    chk("mid_reset_no_ack", {p0_ack, p0_err}, 2'b00);
    tick();
    chk("mid_reset_acks", n_ack0, b0 + 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
